// File: rtl/seq_div.sv
// Iterative unsigned divider: one restoring shift-subtract step per clock.
// Divide-by-zero short-circuits straight to the done state.
module seq_div #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             divz_q, divz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH:0]   prem_step;
  logic [WIDTH-1:0] dvd_step;
  logic             accept;
  logic             last;

  // dvd_q shifts the dividend out MSB-first while quotient bits shift in at the LSB.
  always_comb begin
    shifted   = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    diff      = shifted - {1'b0, dvs_q};
    ge        = (shifted >= {1'b0, dvs_q});
    prem_step = ge ? diff : shifted;
    dvd_step  = {dvd_q[WIDTH-2:0], ge};
    accept    = start && (state_q != StRun);
    last      = (cnt_q == CntW'(1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    out_d   = out_q;
    rem_d   = rem_q;
    divz_d  = divz_q;

    if (accept) begin
      dvd_d  = in1;
      dvs_d  = in2;
      prem_d = '0;
      if (in2 == '0) begin
        state_d = StDone;
        cnt_d   = '0;
        out_d   = '1;
        rem_d   = in1;
        divz_d  = 1'b1;
      end else begin
        state_d = StRun;
        cnt_d   = CntW'(WIDTH);
      end
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StRun: begin
          dvd_d  = dvd_step;
          prem_d = prem_step;
          cnt_d  = cnt_q - CntW'(1);
          if (last) begin
            state_d = StDone;
            out_d   = dvd_step;
            rem_d   = prem_step[WIDTH-1:0];
            divz_d  = 1'b0;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      divz_q  <= divz_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign out      = out_q;
  assign rem      = rem_q;
  assign div_zero = divz_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed corner cases plus randomized operands
// compared against plain integer division.
module tb_seq_div;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic [W-1:0] rem;
  logic         div_zero;

  int checks = 0;
  int passed = 0;

  seq_div #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in1      (in1),
    .in2      (in2),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .rem      (rem),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Drives one request and scrambles operands after acceptance; lat counts edges
  // after the accepting edge until done is seen (-1 on timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_n);
    @(negedge clk);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    in1    = W'($urandom_range(0, 255));
    in2    = W'($urandom_range(0, 255));
    lat    = 0;
    busy_n = 0;
    while (!done && lat < 200) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, div_zero, out, rem} !== '0)
      $display("FAIL reset_state: got %0h want 0", {busy, done, div_zero, out, rem});
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] av [5] = '{8'd100, 8'd5, 8'd255, 8'd3, 8'd255};
    logic [W-1:0] bv [5] = '{8'd7, 8'd0, 8'd1, 8'd200, 8'd255};
    logic [W-1:0] q, r;
    logic z;
    int lat, bn, exp_lat;
    for (int i = 0; i < 5; i++) begin
      model(av[i], bv[i], q, r, z);
      exp_lat = (bv[i] == '0) ? 0 : int'(W);
      run_op(av[i], bv[i], lat, bn);
      checks++;
      if (lat !== exp_lat) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat);
      else passed++;
      checks++;
      if (bn !== exp_lat) $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bn, exp_lat);
      else passed++;
      checks++;
      if ({out, rem, div_zero} !== {q, r, z})
        $display("FAIL dir%0d_result: got q=%0d r=%0d z=%0d want q=%0d r=%0d z=%0d",
                 i, out, rem, div_zero, q, r, z);
      else passed++;
      checks++;
      if (busy !== 1'b0) $display("FAIL dir%0d_busy_with_done: got %0b want 0", i, busy);
      else passed++;
      @(negedge clk);
      checks++;
      if ({done, out, rem} !== {1'b0, q, r})
        $display("FAIL dir%0d_pulse_hold: got done=%0b q=%0d r=%0d want done=0 q=%0d r=%0d",
                 i, done, out, rem, q, r);
      else passed++;
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    logic [W-1:0] q_seen = '0, r_seen = '0;
    logic z_seen = 1'b1;
    @(negedge clk);
    in1 = 8'd100; in2 = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    in1 = 8'd200; in2 = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in1 = 8'd9; in2 = 8'd0;
    repeat (20) begin
      if (done) begin
        pulses++;
        q_seen = out; r_seen = rem; z_seen = div_zero;
      end
      @(negedge clk);
    end
    checks++;
    if (pulses !== 1) $display("FAIL ignore_pulses: got %0d want 1", pulses);
    else passed++;
    checks++;
    if ({q_seen, r_seen, z_seen} !== {8'd14, 8'd2, 1'b0})
      $display("FAIL ignore_result: got q=%0d r=%0d z=%0d want q=14 r=2 z=0",
               q_seen, r_seen, z_seen);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, bn, bad_hold;
    run_op(8'd100, 8'd7, lat, bn);
    checks++;
    if ({done, out, rem} !== {1'b1, 8'd14, 8'd2})
      $display("FAIL b2b_first: got done=%0b q=%0d r=%0d want done=1 q=14 r=2", done, out, rem);
    else passed++;
    in1 = 8'd200; in2 = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in1 = 8'd1; in2 = 8'd1;
    checks++;
    if ({busy, done} !== 2'b10)
      $display("FAIL b2b_no_gap: got busy=%0b done=%0b want busy=1 done=0", busy, done);
    else passed++;
    lat = 0;
    bad_hold = 0;
    while (!done && lat < 200) begin
      if (out !== 8'd14 || rem !== 8'd2) bad_hold++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (bad_hold !== 0) $display("FAIL b2b_hold_during_run: got %0d bad cycles want 0", bad_hold);
    else passed++;
    checks++;
    if (lat !== int'(W)) $display("FAIL b2b_latency: got %0d want %0d", lat, W);
    else passed++;
    checks++;
    if ({out, rem, div_zero} !== {8'd22, 8'd2, 1'b0})
      $display("FAIL b2b_result: got q=%0d r=%0d z=%0d want q=22 r=2 z=0", out, rem, div_zero);
    else passed++;
  endtask

  task automatic test_reset_abort();
    int lat, pulses;
    @(negedge clk);
    in1 = 8'd100; in2 = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_zero, out, rem} !== '0)
      $display("FAIL abort_immediate: got %0h want 0", {busy, done, div_zero, out, rem});
    else passed++;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, div_zero, out, rem} !== '0)
      $display("FAIL abort_held: got %0h want 0", {busy, done, div_zero, out, rem});
    else passed++;
    reset = 1'b0;
    in1 = 8'd100; in2 = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10)
      $display("FAIL abort_first_edge_accept: got busy=%0b done=%0b want 1 0", busy, done);
    else passed++;
    lat = 0;
    pulses = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== int'(W)) $display("FAIL abort_rerun_latency: got %0d want %0d", lat, W);
    else passed++;
    checks++;
    if ({out, rem, div_zero} !== {8'd14, 8'd2, 1'b0})
      $display("FAIL abort_rerun_result: got q=%0d r=%0d z=%0d want q=14 r=2 z=0",
               out, rem, div_zero);
    else passed++;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) $display("FAIL abort_stray_done: got %0d want 0", pulses);
    else passed++;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r;
    logic z;
    int lat, bn, exp_lat;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
      model(a, b, q, r, z);
      exp_lat = (b == '0) ? 0 : int'(W);
      run_op(a, b, lat, bn);
      checks++;
      if (lat !== exp_lat) $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_lat);
      else passed++;
      checks++;
      if ({out, rem, div_zero} !== {q, r, z})
        $display("FAIL rnd%0d_result %0d/%0d: got q=%0d r=%0d z=%0d want q=%0d r=%0d z=%0d",
                 i, a, b, out, rem, div_zero, q, r, z);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand/result width in bits; legal range 2..64.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request to begin a division; sampled on clk rising edge.
REQ-005 in1  in  WIDTH  dividend, unsigned.
REQ-006 in2  in  WIDTH  divisor, unsigned.
REQ-007 busy  out  1  high while an iterative division is in progress.
REQ-008 done  out  1  single-cycle pulse when results are valid.
REQ-009 out  out  WIDTH  quotient, registered.
REQ-010 rem  out  WIDTH  remainder, registered.
REQ-011 div_zero  out  1  high when the last completed operation had in2 == 0.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 start SHALL be accepted on an edge where the state is IDLE or DONE; start SHALL be ignored in RUN.
REQ-014 On acceptance the block SHALL capture in1 and in2 into internal registers; input changes after acceptance SHALL have no effect on the operation.
REQ-015 Acceptance with in2 != 0: the state SHALL go to RUN with the iteration counter = WIDTH.
REQ-016 RUN SHALL perform one restoring shift-subtract iteration per cycle, MSB of the dividend first, using a WIDTH+1-bit partial remainder so no overflow occurs for any operand values.
REQ-017 On the WIDTH-th RUN edge, the state SHALL go to DONE, out/rem SHALL be loaded with floor(in1/in2) and in1 mod in2, and div_zero SHALL be cleared.
REQ-018 Latency: for an accept at edge k, done SHALL be high during the cycle after edge k+WIDTH.
REQ-019 Acceptance with in2 == 0: the state SHALL go directly to DONE at that edge, with out = all ones, rem = captured in1 and div_zero = 1, so done is high in the cycle after the accepting edge.
REQ-020 busy SHALL equal (state == RUN); done SHALL equal (state == DONE); the two SHALL never be high together.
REQ-021 DONE SHALL last exactly one cycle, then go to IDLE unless start is high, in which case a new operation is accepted at that edge (back-to-back, no idle gap).
REQ-022 out, rem and div_zero SHALL hold their values from the last completion until the next completion, including through IDLE and RUN of a later operation.
REQ-023 Partial results SHALL never be visible on out/rem during RUN.

Reset
REQ-024 While reset is high, the state SHALL be IDLE, and busy, done, div_zero, out, rem and all internal registers SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL abort it immediately and asynchronously; no done pulse SHALL follow, and the aborted result SHALL be discarded.
REQ-026 After reset deasserts, the first rising edge SHALL be able to accept start.

Verification (WIDTH=8)
REQ-027 in1=100, in2=7, start at edge k -> busy for 8 cycles, done in the cycle after edge k+8, out=14, rem=2, div_zero=0.
REQ-028 in1=5, in2=0 -> done in the cycle after the accepting edge, out=0xFF, rem=5, div_zero=1; a following 255/1 -> out=255, rem=0, div_zero=0.
REQ-029 in1=3, in2=200 -> out=0, rem=3; in1=255, in2=255 -> out=1, rem=0.
REQ-030 start pulsed again mid-RUN while in1/in2 are changed -> ignored; the original result completes unchanged, with only one done pulse.
REQ-031 start held high through the DONE cycle with new operands 200/9 -> accepted with no gap; the next done carries out=22, rem=2.
REQ-032 reset pulsed at RUN cycle 4 -> all outputs 0 immediately, no done pulse; a new 100/7 afterwards yields 14 rem 2.
